// File: rtl/controller.sv
// Top-level sequencer: initialises memory, then walks the serial, systolic and custom
// compute phases over four stride windows before handing results to the display.
module controller (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       serial_mode_done,
    input  logic       weight_Preloader_done,
    input  logic       feature_Loader_done,
    input  logic       custom_mode_done,
    input  logic       display_done,
    output logic       rst_computation_module,
    output logic       rst_display_module,
    output logic [7:0] data,
    output logic [5:0] addr_0,
    output logic       mem_sel,
    output logic [7:0] serial_mode_feature_baseaddr,
    output logic [5:0] systolic_mode_feature_baseaddr,
    output logic       serial_mode_en,
    output logic       Weight_Preloader_en,
    output logic       Feature_Loader_en,
    output logic       custom_mode_en,
    output logic       display_mode_reg_en,
    output logic       systolic_mode,
    output logic [1:0] c_reg_sel,
    output logic [1:0] computation_mode_sel
);

    typedef enum logic [3:0] {
        IDLE, INIT, SERIAL, W_PRELOAD, F_LOAD, DRAIN, CUSTOM, DISPLAY, DONE
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] s, s_nxt;
    logic       gap, gap_nxt;
    logic [4:0] cnt, cnt_nxt;
    logic [2:0] base_nxt;
    logic [7:0] data_nxt;

    always_comb begin
        state_nxt = state;
        s_nxt     = s;
        gap_nxt   = 1'b0;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (start) begin
                state_nxt = INIT;
                cnt_nxt   = '0;
            end
            INIT: if (cnt == 5'd24) begin
                state_nxt = SERIAL;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + 5'd1;
            end
            SERIAL: if (!gap && serial_mode_done) begin
                if (s == 2'd3) begin
                    s_nxt     = '0;
                    state_nxt = W_PRELOAD;
                end else begin
                    s_nxt   = s + 2'd1;
                    gap_nxt = 1'b1;
                end
            end
            W_PRELOAD: if (weight_Preloader_done) state_nxt = F_LOAD;
            F_LOAD: if (!gap && feature_Loader_done) begin
                if (s == 2'd3) begin
                    s_nxt     = '0;
                    state_nxt = DRAIN;
                    cnt_nxt   = '0;
                end else begin
                    s_nxt   = s + 2'd1;
                    gap_nxt = 1'b1;
                end
            end
            DRAIN: if (cnt == 5'd2) begin
                state_nxt = CUSTOM;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + 5'd1;
            end
            CUSTOM:  if (custom_mode_done) state_nxt = DISPLAY;
            DISPLAY: if (display_done)     state_nxt = DONE;
            DONE:    if (!start)           state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copy tracks the state register.
    always_comb begin
        base_nxt = {s_nxt[1], 1'b0, s_nxt[0]};
        data_nxt = '0;
        if (state_nxt == INIT)
            data_nxt = (cnt_nxt < 5'd16) ? {3'b000, cnt_nxt} + 8'd1 : {3'b000, cnt_nxt} - 8'd15;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state                          <= IDLE;
            s                              <= '0;
            gap                            <= 1'b0;
            cnt                            <= '0;
            rst_computation_module         <= 1'b0;
            rst_display_module             <= 1'b0;
            data                           <= '0;
            addr_0                         <= '0;
            mem_sel                        <= 1'b1;
            serial_mode_feature_baseaddr   <= '0;
            systolic_mode_feature_baseaddr <= '0;
            serial_mode_en                 <= 1'b0;
            Weight_Preloader_en            <= 1'b0;
            Feature_Loader_en              <= 1'b0;
            custom_mode_en                 <= 1'b0;
            display_mode_reg_en            <= 1'b0;
            systolic_mode                  <= 1'b0;
            c_reg_sel                      <= '0;
            computation_mode_sel           <= '0;
        end else begin
            state                          <= state_nxt;
            s                              <= s_nxt;
            gap                            <= gap_nxt;
            cnt                            <= cnt_nxt;
            rst_computation_module         <= !(state_nxt inside {IDLE, INIT});
            rst_display_module             <= state_nxt inside {DISPLAY, DONE};
            data                           <= data_nxt;
            addr_0                         <= (state_nxt == INIT) ? {1'b0, cnt_nxt} : '0;
            mem_sel                        <= state_nxt inside {IDLE, INIT, DONE};
            serial_mode_feature_baseaddr   <= {5'b00000, base_nxt};
            systolic_mode_feature_baseaddr <= {3'b000, base_nxt};
            serial_mode_en                 <= (state_nxt == SERIAL) && !gap_nxt;
            Weight_Preloader_en            <= (state_nxt == W_PRELOAD);
            Feature_Loader_en              <= (state_nxt == F_LOAD) && !gap_nxt;
            custom_mode_en                 <= (state_nxt == CUSTOM);
            display_mode_reg_en            <= (state_nxt == DISPLAY);
            systolic_mode                  <= (state_nxt == F_LOAD);
            c_reg_sel                      <= (state_nxt inside {SERIAL, F_LOAD}) ? s_nxt : 2'd0;
            case (state_nxt)
                SERIAL:                   computation_mode_sel <= 2'b01;
                W_PRELOAD, F_LOAD, DRAIN: computation_mode_sel <= 2'b10;
                CUSTOM:                   computation_mode_sel <= 2'b11;
                default:                  computation_mode_sel <= 2'b00;
            endcase
        end
    end

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller: a phase/step reference model checked every cycle,
// plus directed literal checks along the full flow, out-of-state dones and mid-flow reset.
module tb_controller;

    logic       clk = 1'b0;
    logic       rst, start;
    logic [4:0] dn;
    logic       rst_computation_module, rst_display_module, mem_sel;
    logic [7:0] data, serial_mode_feature_baseaddr;
    logic [5:0] addr_0, systolic_mode_feature_baseaddr;
    logic       serial_mode_en, Weight_Preloader_en, Feature_Loader_en, custom_mode_en;
    logic       display_mode_reg_en, systolic_mode;
    logic [1:0] c_reg_sel, computation_mode_sel;
    logic [4:0] en_v;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    controller dut (
        .clk                            (clk),
        .rst                            (rst),
        .start                          (start),
        .serial_mode_done               (dn[0]),
        .weight_Preloader_done          (dn[1]),
        .feature_Loader_done            (dn[2]),
        .custom_mode_done               (dn[3]),
        .display_done                   (dn[4]),
        .rst_computation_module         (rst_computation_module),
        .rst_display_module             (rst_display_module),
        .data                           (data),
        .addr_0                         (addr_0),
        .mem_sel                        (mem_sel),
        .serial_mode_feature_baseaddr   (serial_mode_feature_baseaddr),
        .systolic_mode_feature_baseaddr (systolic_mode_feature_baseaddr),
        .serial_mode_en                 (serial_mode_en),
        .Weight_Preloader_en            (Weight_Preloader_en),
        .Feature_Loader_en              (Feature_Loader_en),
        .custom_mode_en                 (custom_mode_en),
        .display_mode_reg_en            (display_mode_reg_en),
        .systolic_mode                  (systolic_mode),
        .c_reg_sel                      (c_reg_sel),
        .computation_mode_sel           (computation_mode_sel)
    );

    assign en_v = {display_mode_reg_en, custom_mode_en, Feature_Loader_en,
                   Weight_Preloader_en, serial_mode_en};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model. Phase: 0 idle, 1 init, 2 serial, 3 weight preload, 4 feature load,
    // 5 drain, 6 custom, 7 display, 8 done. k counts steps inside init/drain.
    int ph = 0, ms = 0, mk = 0;
    bit mgap = 1'b0;

    always @(posedge clk) begin
        mgap <= 1'b0;
        if (!rst) begin
            ph <= 0; ms <= 0; mk <= 0;
        end else begin
            case (ph)
                0: if (start) begin ph <= 1; mk <= 0; end
                1: if (mk == 24) begin ph <= 2; mk <= 0; end else mk <= mk + 1;
                2, 4: if (!mgap && dn[ph == 2 ? 0 : 2]) begin
                    if (ms == 3) begin ms <= 0; mk <= 0; ph <= ph + 1; end
                    else begin ms <= ms + 1; mgap <= 1'b1; end
                end
                3: if (dn[1]) ph <= 4;
                5: if (mk == 2) ph <= 6; else mk <= mk + 1;
                6: if (dn[3]) ph <= 7;
                7: if (dn[4]) ph <= 8;
                8: if (!start) ph <= 0;
                default: ph <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        int een, ecms, ebase;
        een = 0;
        if (ph == 2 && !mgap) een = 1;
        if (ph == 3)          een = 2;
        if (ph == 4 && !mgap) een = 4;
        if (ph == 6)          een = 8;
        if (ph == 7)          een = 16;
        ecms  = (ph == 2) ? 1 : (ph >= 3 && ph <= 5) ? 2 : (ph == 6) ? 3 : 0;
        ebase = (ms / 2) * 4 + ms % 2;
        chk("m_enables", en_v, een);
        chk("m_mem_sel", mem_sel, (ph <= 1 || ph == 8) ? 1 : 0);
        chk("m_rst_comp", rst_computation_module, (ph >= 2) ? 1 : 0);
        chk("m_rst_disp", rst_display_module, (ph >= 7) ? 1 : 0);
        chk("m_addr_0", addr_0, (ph == 1) ? mk : 0);
        chk("m_data", data, (ph == 1) ? ((mk < 16) ? mk + 1 : mk - 15) : 0);
        chk("m_serial_base", serial_mode_feature_baseaddr, ebase);
        chk("m_systolic_base", systolic_mode_feature_baseaddr, ebase);
        chk("m_c_reg_sel", c_reg_sel, (ph == 2 || ph == 4) ? ms : 0);
        chk("m_mode_sel", computation_mode_sel, ecms);
        chk("m_systolic_mode", systolic_mode, (ph == 4) ? 1 : 0);
    end

    task automatic wait_en(input int idx, input string name);
        int n = 0;
        while (en_v[idx] !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (en_v[idx] !== 1'b1) begin
            compared++;
            mismatched++;
            $display("FAIL timeout_%s: enable %0d still %b after %0d cycles, required 1", name, idx, en_v[idx], n);
        end
    endtask

    task automatic pulse(input int idx);
        dn[idx] = 1'b1;
        @(negedge clk);
        #1 dn[idx] = 1'b0;
    endtask

    initial begin
        int tbl[4];
        tbl = '{0, 1, 4, 5};
        rst = 1'b0; start = 1'b0; dn = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_sel", mem_sel, 1);
        chk("rst_addr_0", addr_0, 0);
        chk("rst_rst_comp", rst_computation_module, 0);
        chk("rst_mode_sel", computation_mode_sel, 0);
        #1 rst = 1'b1; start = 1'b1;

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            chk("init_addr", addr_0, i);
            chk("init_data", data, (i < 16) ? i + 1 : i - 15);
            chk("init_mem_sel", mem_sel, 1);
        end
        @(negedge clk);
        chk("serial_at_cycle26", serial_mode_en, 1);

        for (int s = 0; s < 4; s++) begin
            wait_en(0, "serial");
            chk("serial_base", serial_mode_feature_baseaddr, tbl[s]);
            chk("serial_c_reg_sel", c_reg_sel, s);
            if (s == 1) begin
                pulse(3);
                chk("oos_custom_done_serial_en", serial_mode_en, 1);
                chk("oos_custom_done_mode_sel", computation_mode_sel, 1);
            end
            pulse(0);
            if (s < 3) chk("serial_gap", serial_mode_en, 0);
        end

        wait_en(1, "wpre");
        chk("wpre_systolic_mode", systolic_mode, 0);
        pulse(1);

        for (int s = 0; s < 4; s++) begin
            wait_en(2, "fload");
            chk("fload_base", systolic_mode_feature_baseaddr, tbl[s]);
            chk("fload_c_reg_sel", c_reg_sel, s);
            chk("fload_systolic_mode", systolic_mode, 1);
            pulse(2);
        end

        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            chk("drain_enables", en_v, 0);
            chk("drain_mode_sel", computation_mode_sel, 2);
        end
        @(negedge clk);
        chk("custom_en_after_drain", custom_mode_en, 1);

        pulse(3);
        chk("display_en", display_mode_reg_en, 1);
        chk("display_rst_disp", rst_display_module, 1);
        chk("display_mem_sel", mem_sel, 0);
        pulse(4);
        chk("done_mem_sel", mem_sel, 1);
        chk("done_enables", en_v, 0);
        repeat (2) @(negedge clk);
        chk("done_hold_rst_comp", rst_computation_module, 1);
        #1 start = 1'b0;
        @(negedge clk);
        chk("idle_rst_comp", rst_computation_module, 0);
        chk("idle_rst_disp", rst_display_module, 0);

        // Second run: out-of-state done in weight preload, held feature done, reset mid F_LOAD.
        #1 start = 1'b1;
        for (int s = 0; s < 4; s++) begin
            wait_en(0, "serial2");
            pulse(0);
        end
        wait_en(1, "wpre2");
        pulse(4);
        chk("oos_display_done_wpre", Weight_Preloader_en, 1);
        pulse(1);
        wait_en(2, "fload2");
        dn[2] = 1'b1;
        repeat (3) @(negedge clk);
        chk("held_done_c_reg_sel", c_reg_sel, 2);
        chk("held_done_gap", Feature_Loader_en, 0);
        #1 dn[2] = 1'b0;
        @(negedge clk);
        chk("held_done_en", Feature_Loader_en, 1);
        chk("held_done_base", systolic_mode_feature_baseaddr, 4);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_mem_sel", mem_sel, 1);
        chk("midrst_enables", en_v, 0);
        chk("midrst_systolic_mode", systolic_mode, 0);
        chk("midrst_c_reg_sel", c_reg_sel, 0);
        chk("midrst_base", systolic_mode_feature_baseaddr, 0);
        chk("midrst_rst_comp", rst_computation_module, 0);
        chk("midrst_mode_sel", computation_mode_sel, 0);
        #1 rst = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        chk("wait_start_addr", addr_0, 0);
        chk("wait_start_mem_sel", mem_sel, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 SHALL have ports: clk in 1, sole clock; all state changes on rising edge.
REQ-002 SHALL have: rst in 1, one clock; reset is synchronous and active-low.
REQ-003 SHALL have: start in 1, level request to run the whole flow (init -> serial -> systolic -> custom -> display).
REQ-004 SHALL have done inputs, 1 bit each: serial_mode_done, weight_Preloader_done, feature_Loader_done, custom_mode_done, display_done.
REQ-005 SHALL have outputs rst_computation_module 1 and rst_display_module 1; both are active-low resets for downstream blocks.
REQ-006 SHALL have outputs data 8 and addr_0 6, the memory-initialisation write data and address.
REQ-007 SHALL have output mem_sel 1: 1 = controller owns memory, 0 = computation owns memory.
REQ-008 SHALL have outputs serial_mode_feature_baseaddr 8 and systolic_mode_feature_baseaddr 6, the window base address of the current stride.
REQ-009 SHALL have enable outputs of 1 bit each: serial_mode_en, Weight_Preloader_en, Feature_Loader_en, custom_mode_en, display_mode_reg_en.
REQ-010 SHALL have output systolic_mode 1: 0 = weight preload, 1 = feature load.
REQ-011 SHALL have outputs c_reg_sel 2, result-register index (0=c11, 1=c12, 2=c21, 3=c22), and computation_mode_sel 2 (00 idle, 01 serial, 10 systolic, 11 custom).

Function
REQ-012 SHALL be a Moore FSM; all outputs SHALL be registered or decoded only from state and counters.
REQ-013 FSM states SHALL be IDLE, INIT, SERIAL, W_PRELOAD, F_LOAD, DRAIN, CUSTOM, DISPLAY, DONE.
REQ-014 IDLE SHALL move to INIT on the first rising edge that samples start=1.
REQ-015 INIT SHALL last 25 cycles with mem_sel=1 and addr_0 stepping 0..24, one address per cycle.
REQ-016 INIT data SHALL be addr_0+1 for addr_0 0..15 (4x4 feature map) and addr_0-15 for addr_0 16..24 (3x3 weight); after addr_0=24, INIT SHALL go to SERIAL.
REQ-017 A 2-bit stride counter s SHALL select window base addresses 0, 1, 4, 5 for s = 0..3.
REQ-018 Both base-address outputs SHALL show the base address for s, zero-extended to their width; c_reg_sel SHALL equal s in SERIAL and F_LOAD, and 0 elsewhere.
REQ-019 SERIAL SHALL assert serial_mode_en and set computation_mode_sel=01.
REQ-020 In SERIAL, a sampled serial_mode_done SHALL deassert serial_mode_en for exactly one gap cycle and increment s; serial_mode_en SHALL then reassert with the new base address.
REQ-021 The serial_mode_done with s=3 SHALL clear s and go to W_PRELOAD.
REQ-022 W_PRELOAD SHALL assert Weight_Preloader_en, systolic_mode=0 and computation_mode_sel=10; weight_Preloader_done SHALL move it to F_LOAD.
REQ-023 F_LOAD SHALL assert Feature_Loader_en, systolic_mode=1 and computation_mode_sel=10.
REQ-024 In F_LOAD, feature_Loader_done SHALL follow the same one-gap-cycle/increment rule as SERIAL; at s=3 it SHALL go to DRAIN.
REQ-025 DRAIN SHALL last exactly 3 cycles (systolic pipeline flush), keep computation_mode_sel=10 with all enables low, then go to CUSTOM.
REQ-026 CUSTOM SHALL assert custom_mode_en and set computation_mode_sel=11; custom_mode_done SHALL move it to DISPLAY.
REQ-027 DISPLAY SHALL assert display_mode_reg_en and drive rst_display_module=1; display_done SHALL move it to DONE.
REQ-028 DONE SHALL hold all enables low and return to IDLE when start is sampled 0.
REQ-029 mem_sel SHALL be 1 in IDLE, INIT and DONE, and 0 otherwise.
REQ-030 rst_computation_module SHALL be 0 in IDLE and INIT, and 1 from SERIAL through DONE; rst_display_module SHALL be 0 except in DISPLAY and DONE.
REQ-031 A done input SHALL be ignored unless it belongs to the current state, and ignored during gap cycles; a done held high SHALL count once per enable period.
REQ-032 At most one enable SHALL be high in any cycle.

Reset
REQ-033 rst=0 at a rising edge SHALL force IDLE and s=0 from any state, including mid-flow.
REQ-034 During reset, all enables, systolic_mode, c_reg_sel, computation_mode_sel, data, addr_0, base addresses, rst_computation_module and rst_display_module SHALL be 0, and mem_sel SHALL be 1.
REQ-035 After reset is released, the block SHALL wait for start.

Verification
REQ-036 Reset, then start=1 -> 25 INIT cycles with addr_0 0..24; data 1..16 then 1..9; mem_sel=1; SERIAL entered at cycle 26.
REQ-037 Four 1-cycle serial_mode_done pulses -> serial base addresses 0, 1, 4, 5 and c_reg_sel 0..3, one gap cycle after each pulse, then Weight_Preloader_en=1 with systolic_mode=0.
REQ-038 weight_Preloader_done, then four feature_Loader_done pulses -> systolic base addresses 0, 1, 4, 5 with systolic_mode=1, then 3 DRAIN cycles, then custom_mode_en=1.
REQ-039 custom_mode_done -> display_mode_reg_en=1 and rst_display_module=1; display_done -> DONE with mem_sel=1; start=0 -> IDLE.
REQ-040 Out-of-state done pulses (e.g. custom_mode_done during SERIAL) -> no state change; rst=0 asserted during F_LOAD -> IDLE next edge with all outputs at reset values.
